// File: rtl/lnrv_exu_alu_arb_pkg.sv
// Shared definitions for the EXU ALU arbiter and its one-hot arbiter core.
package lnrv_exu_alu_arb_pkg;

  localparam int unsigned ALU_OP_BUS_WIDTH = 8;

  // Arbitration mode encodings
  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Index width that stays at least one bit wide for tiny requester counts
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lnrv_rr_arb.sv
// One-hot arbiter: fixed priority (index 0 highest) or round-robin starting at ptr.
module lnrv_rr_arb
  import lnrv_exu_alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               mode,
  output logic [NUM_REQ-1:0] grant
);

  int unsigned start;
  int unsigned pos;
  logic        found;

  // Scan from the start index, wrapping modulo NUM_REQ; first asserted request wins
  always_comb begin
    grant = '0;
    found = 1'b0;
    start = mode ? 32'(ptr) : 32'd0;
    pos   = 32'd0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = start + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && req[pos[PTR_W-1:0]]) begin
        grant[pos[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lnrv_exu_alu_arb.sv
// Arbitrates NUM_REQ requesters onto the shared ALU through a one-entry output register.
module lnrv_exu_alu_arb
  import lnrv_exu_alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned OP_W     = ALU_OP_BUS_WIDTH,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ARB_MODE = ARB_FIXED,
  parameter int unsigned ID_W     = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_vld,
  output logic [NUM_REQ-1:0]        req_rdy,
  input  logic [NUM_REQ*OP_W-1:0]   req_op_bus,
  input  logic [NUM_REQ*DATA_W-1:0] req_in1,
  input  logic [NUM_REQ*DATA_W-1:0] req_in2,
  output logic                      alu_op_vld,
  input  logic                      alu_op_rdy,
  output logic [OP_W-1:0]           alu_op_bus,
  output logic [DATA_W-1:0]         alu_in1,
  output logic [DATA_W-1:0]         alu_in2,
  output logic [ID_W-1:0]           alu_src_id,
  output logic                      arb_conflict
);

  localparam logic RrMode = (ARB_MODE == ARB_RR);

  logic               load;
  logic               accept;
  logic               multi_req;
  logic [NUM_REQ-1:0] grant;
  logic [OP_W-1:0]    sel_op;
  logic [DATA_W-1:0]  sel_in1;
  logic [DATA_W-1:0]  sel_in2;
  logic [ID_W-1:0]    sel_id;

  logic               out_vld_q, out_vld_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [DATA_W-1:0]  in1_q, in1_d;
  logic [DATA_W-1:0]  in2_q, in2_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               conflict_q, conflict_d;
  logic [ID_W-1:0]    ptr_q;

  lnrv_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (ID_W)
  ) u_arb (
    .req   (req_vld),
    .ptr   (ptr_q),
    .mode  (RrMode),
    .grant (grant)
  );

  // The register can take a new op when empty or being drained this cycle
  assign load      = ~out_vld_q | alu_op_rdy;
  assign req_rdy   = grant & {NUM_REQ{load}};
  assign accept    = |(req_vld & req_rdy);
  assign multi_req = |(req_vld & (req_vld - NUM_REQ'(1)));

  // Select the granted requester's payload and index
  always_comb begin
    sel_op  = '0;
    sel_in1 = '0;
    sel_in2 = '0;
    sel_id  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_op  = req_op_bus[i*OP_W +: OP_W];
        sel_in1 = req_in1[i*DATA_W +: DATA_W];
        sel_in2 = req_in2[i*DATA_W +: DATA_W];
        sel_id  = ID_W'(i);
      end
    end
  end

  // Output stage next state: replace on accept, go empty (data held) on idle load
  always_comb begin
    out_vld_d  = out_vld_q;
    op_d       = op_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    id_d       = id_q;
    conflict_d = conflict_q | (load & multi_req);
    if (load) begin
      out_vld_d = accept;
      if (accept) begin
        op_d  = sel_op;
        in1_d = sel_in1;
        in2_d = sel_in2;
        id_d  = sel_id;
      end
    end
  end

  // Output register and sticky conflict flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      op_q       <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      id_q       <= '0;
      conflict_q <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      op_q       <= op_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      id_q       <= id_d;
      conflict_q <= conflict_d;
    end
  end

  if (RrMode) begin : g_rr_ptr
    logic [ID_W-1:0] ptr_d;

    // Pointer moves just past the winner on accept, wrapping at NUM_REQ
    always_comb begin
      ptr_d = ptr_q;
      if (accept) ptr_d = (sel_id == ID_W'(NUM_REQ - 1)) ? '0 : sel_id + 1'b1;
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
    end
  end else begin : g_fixed_ptr
    assign ptr_q = '0;
  end

  assign alu_op_vld   = out_vld_q;
  assign alu_op_bus   = op_q;
  assign alu_in1      = in1_q;
  assign alu_in2      = in2_q;
  assign alu_src_id   = id_q;
  assign arb_conflict = conflict_q;

endmodule

// File: tb/tb_lnrv_exu_alu_arb.sv
// Bench: fixed-priority and round-robin instances share stimulus and are checked
// against a behavioural model every cycle, plus directed literal expectations.
module tb_lnrv_exu_alu_arb;

  localparam int unsigned N   = 4;
  localparam int unsigned OPW = 8;
  localparam int unsigned DW  = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req_vld;
  logic alu_op_rdy;
  logic [OPW-1:0] op[N];
  logic [DW-1:0] a1[N];
  logic [DW-1:0] a2[N];
  logic [N*OPW-1:0] op_bus;
  logic [N*DW-1:0] in1_bus;
  logic [N*DW-1:0] in2_bus;

  logic [N-1:0] rdy_o[2];
  logic vld_o[2];
  logic [OPW-1:0] op_o[2];
  logic [DW-1:0] i1_o[2];
  logic [DW-1:0] i2_o[2];
  logic [1:0] id_o[2];
  logic conf_o[2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      op_bus[i*OPW +: OPW] = op[i];
      in1_bus[i*DW +: DW]  = a1[i];
      in2_bus[i*DW +: DW]  = a2[i];
    end
  end

  lnrv_exu_alu_arb #(
    .NUM_REQ (N), .OP_W (OPW), .DATA_W (DW), .ARB_MODE (0)
  ) dut_fx (
    .clk (clk), .rst_n (rst_n), .req_vld (req_vld), .req_rdy (rdy_o[0]),
    .req_op_bus (op_bus), .req_in1 (in1_bus), .req_in2 (in2_bus),
    .alu_op_vld (vld_o[0]), .alu_op_rdy (alu_op_rdy), .alu_op_bus (op_o[0]),
    .alu_in1 (i1_o[0]), .alu_in2 (i2_o[0]), .alu_src_id (id_o[0]),
    .arb_conflict (conf_o[0])
  );

  lnrv_exu_alu_arb #(
    .NUM_REQ (N), .OP_W (OPW), .DATA_W (DW), .ARB_MODE (1)
  ) dut_rr (
    .clk (clk), .rst_n (rst_n), .req_vld (req_vld), .req_rdy (rdy_o[1]),
    .req_op_bus (op_bus), .req_in1 (in1_bus), .req_in2 (in2_bus),
    .alu_op_vld (vld_o[1]), .alu_op_rdy (alu_op_rdy), .alu_op_bus (op_o[1]),
    .alu_in1 (i1_o[1]), .alu_in2 (i2_o[1]), .alu_src_id (id_o[1]),
    .arb_conflict (conf_o[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Winner by the rules: mode 0 lowest index, mode 1 first at or after ptr, wrapping
  function automatic int winner(input int m, input logic [N-1:0] v, input int p);
    int s;
    int i;
    s = (m == 1) ? p : 0;
    for (int k = 0; k < N; k++) begin
      i = (s + k) % N;
      if (v[i[1:0]]) return i;
    end
    return -1;
  endfunction

  // Model state per instance (0 = fixed, 1 = round-robin)
  logic m_vld[2];
  logic [OPW-1:0] m_op[2];
  logic [DW-1:0] m_i1[2];
  logic [DW-1:0] m_i2[2];
  logic [1:0] m_id[2];
  int m_ptr[2];
  logic m_conf[2];

  always @(negedge clk) begin
    int w;
    logic ld;
    logic [N-1:0] er;
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_vld[m] = 1'b0; m_op[m] = '0; m_i1[m] = '0; m_i2[m] = '0;
        m_id[m] = '0; m_ptr[m] = 0; m_conf[m] = 1'b0;
      end
    end
    for (int m = 0; m < 2; m++) begin
      w  = winner(m, req_vld, m_ptr[m]);
      ld = !m_vld[m] || alu_op_rdy;
      er = (ld && w >= 0) ? (4'b0001 << w) : 4'b0000;
      chk($sformatf("m%0d req_rdy", m), rdy_o[m], er);
      chk($sformatf("m%0d alu_op_vld", m), vld_o[m], m_vld[m]);
      chk($sformatf("m%0d alu_op_bus", m), op_o[m], m_op[m]);
      chk($sformatf("m%0d alu_in1", m), i1_o[m], m_i1[m]);
      chk($sformatf("m%0d alu_in2", m), i2_o[m], m_i2[m]);
      chk($sformatf("m%0d alu_src_id", m), id_o[m], m_id[m]);
      chk($sformatf("m%0d arb_conflict", m), conf_o[m], m_conf[m]);
      if (rst_n) begin
        if (ld && $countones(req_vld) > 1) m_conf[m] = 1'b1;
        if (ld) begin
          m_vld[m] = (w >= 0);
          if (w >= 0) begin
            m_op[m] = op[w];
            m_i1[m] = a1[w];
            m_i2[m] = a2[w];
            m_id[m] = w[1:0];
            if (m == 1) m_ptr[m] = (w + 1) % N;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [OPW-1:0] o, input logic [DW-1:0] x,
                         input logic [DW-1:0] y);
    op[i] = o;
    a1[i] = x;
    a2[i] = y;
  endtask

  initial begin
    int seq[5];
    seq = '{0, 1, 2, 3, 0};
    rst_n      = 1'b0;
    req_vld    = '0;
    alu_op_rdy = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, '0, '0, '0);
    cyc();
    cyc();
    for (int m = 0; m < 2; m++) begin
      chk("reset vld", vld_o[m], 0);
      chk("reset op", op_o[m], 0);
      chk("reset in1", i1_o[m], 0);
      chk("reset in2", i2_o[m], 0);
      chk("reset id", id_o[m], 0);
      chk("reset conflict", conf_o[m], 0);
    end
    rst_n = 1'b1;

    // Single request from index 2
    set_req(2, 8'h05, 32'h11, 32'h22);
    req_vld = 4'b0100;
    #1;
    chk("accept rdy fx", rdy_o[0], 4'b0100);
    chk("accept rdy rr", rdy_o[1], 4'b0100);
    cyc();
    for (int m = 0; m < 2; m++) begin
      chk("single vld", vld_o[m], 1);
      chk("single op", op_o[m], 8'h05);
      chk("single in1", i1_o[m], 32'h11);
      chk("single in2", i2_o[m], 32'h22);
      chk("single id", id_o[m], 2);
    end

    // Backpressure with requester 1 waiting
    set_req(1, 8'h07, 32'h33, 32'h44);
    req_vld    = 4'b0010;
    alu_op_rdy = 1'b0;
    repeat (3) begin
      #1;
      chk("bp rdy", rdy_o[0], 4'b0000);
      chk("bp op held", op_o[0], 8'h05);
      chk("bp vld held", vld_o[0], 1);
      cyc();
    end
    alu_op_rdy = 1'b1;
    #1;
    chk("bp release rdy", rdy_o[0], 4'b0010);
    cyc();
    chk("bp new op", op_o[0], 8'h07);
    chk("bp new in1", i1_o[0], 32'h33);
    chk("bp new id", id_o[0], 1);
    req_vld = '0;
    cyc();
    chk("drain vld", vld_o[0], 0);
    chk("drain op held", op_o[0], 8'h07);
    chk("drain in2 held", i2_o[0], 32'h44);

    // All four requesting: rr rotates, fixed sticks at 0
    rst_n = 1'b0;
    cyc();
    rst_n   = 1'b1;
    req_vld = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rr id seq", id_o[1], seq[k]);
      chk("rr conflict", conf_o[1], 1);
      chk("fx id all", id_o[0], 0);
    end

    // Fixed priority: 1 beats 3 every time
    req_vld = 4'b1010;
    repeat (3) begin
      #1;
      chk("fx starve rdy", rdy_o[0], 4'b0010);
      cyc();
      chk("fx starve id", id_o[0], 1);
      chk("fx conflict", conf_o[0], 1);
    end

    // Streaming from requester 0
    req_vld = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      op[0] = OPW'(8'h40 + k);
      cyc();
      chk("stream vld", vld_o[0], 1);
      chk("stream op", op_o[0], 8'h40 + k);
    end
    req_vld = '0;
    cyc();
    chk("stream end vld", vld_o[0], 0);
    chk("stream end op", op_o[0], 8'h43);

    // Asynchronous reset mid-stream
    req_vld = 4'b0001;
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("async rst vld", vld_o[m], 0);
      chk("async rst op", op_o[m], 0);
      chk("async rst in1", i1_o[m], 0);
      chk("async rst id", id_o[m], 0);
      chk("async rst conflict", conf_o[m], 0);
    end
    cyc();
    rst_n   = 1'b1;
    req_vld = 4'b1111;
    cyc();
    chk("rr ptr after reset", id_o[1], 0);

    // Randomised traffic with occasional resets
    repeat (3000) begin
      cyc();
      for (int i = 0; i < N; i++) set_req(i, OPW'($urandom), $urandom, $urandom);
      req_vld    = N'($urandom_range(0, 15));
      alu_op_rdy = ($urandom_range(0, 3) != 0);
      rst_n      = ($urandom_range(0, 199) != 0);
    end
    rst_n = 1'b1;
    cyc();
    cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lnrv_exu_alu_arb.md
# lnrv_exu_alu_arb

Parametrised arbiter and one-entry pipeline register in front of the shared EXU ALU. It takes NUM_REQ requesters (regular, branch, CSR, LSU, plus any future units), grants one per cycle by fixed priority or round-robin, and registers the winning operation so the ALU sees a timing-clean valid/ready source. It tags each operation with its source index so results can be steered back, and flags any same-cycle multi-request in the single-issue pipe.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- OP_W, `ALU_OP_BUS_WIDTH: operation bus width.
- DATA_W, 32: operand width.
- ARB_MODE, 0: 0 = fixed priority (index 0 highest), 1 = round-robin.
- ID_W, $clog2(NUM_REQ): source-id width.

Ports:
- clk  in  1  core clock; single clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_vld  in  NUM_REQ  per-requester valid.
- req_rdy  out  NUM_REQ  per-requester ready.
- req_op_bus  in  NUM_REQ*OP_W  packed op buses, requester i at [i*OP_W +: OP_W].
- req_in1  in  NUM_REQ*DATA_W  packed operand 1.
- req_in2  in  NUM_REQ*DATA_W  packed operand 2.
- alu_op_vld  out  1  registered valid to the ALU.
- alu_op_rdy  in  1  ALU ready.
- alu_op_bus  out  OP_W  registered op bus.
- alu_in1  out  DATA_W  registered operand 1.
- alu_in2  out  DATA_W  registered operand 2.
- alu_src_id  out  ID_W  index of the requester that issued the held op.
- arb_conflict  out  1  sticky: set when more than one req_vld is high in a cycle in which an accept can occur.

## Operation
- Output stage is one entry: out_vld plus registered op bus, in1, in2 and src_id. `load = ~out_vld | alu_op_rdy`.
- Grant is one-hot over req_vld and combinational from the current req_vld and the priority pointer.
  - Mode 0: lowest asserted index wins.
  - Mode 1: first asserted index at or after ptr, wrapping modulo NUM_REQ.
- req_rdy[i] = grant[i] & load. Non-granted requesters see req_rdy = 0.
- Accept occurs when req_vld[i] & req_rdy[i]. On accept, the register captures requester i's op, in1, in2 and id i, and out_vld becomes 1.
- If load is high and no request is valid, out_vld becomes 0 and the data registers hold their previous values.
- If alu_op_rdy is low and out_vld is high, everything holds and all req_rdy are 0.
- Round-robin pointer: on accept from i, ptr becomes (i+1) mod NUM_REQ. It does not move without an accept. Mode 0 has no pointer logic.
- arb_conflict sets when popcount(req_vld) > 1 and load is high. It clears only on reset. Arbitration proceeds normally when it sets.
- Requesters must hold vld and payload stable until accepted. The block does not check this.

## Timing
- Latency is 1 cycle from accept to alu_op_vld. Sustained throughput is 1 op/cycle when alu_op_rdy stays high.
- Simultaneous drain and accept in the same cycle: the register is replaced with no bubble.
- Reset values: alu_op_vld = 0, alu_op_bus = 0, alu_in1 = 0, alu_in2 = 0, alu_src_id = 0, ptr = 0, arb_conflict = 0. req_rdy resolves to the grant, because load = 1 after reset.
- Reset mid-operation drops the held op. There is no replay.
- Pointer wrap: an accept from NUM_REQ-1 sets ptr to 0.
- NUM_REQ that is not a power of two: ptr never takes values ≥ NUM_REQ.

## Structure
- A shared package/define file holds the ALU_OP_BUS_WIDTH define, ARB_MODE encodings (ARB_FIXED = 0, ARB_RR = 1) and a clog2 helper where needed.
- Sub-module lnrv_rr_arb: a NUM_REQ-wide round-robin/fixed one-hot arbiter with inputs req, ptr and mode, and output grant. It is reusable by the LSU and bus arbiters. The top holds the output register, pointer and conflict flag.

## Test plan
- Reset, then req_vld = 4'b0100 with op = 0x5, in1 = 0x11, in2 = 0x22, ALU ready → next cycle alu_op_vld = 1, op = 0x5, in1 = 0x11, in2 = 0x22, alu_src_id = 2, req_rdy = 4'b0100 during the accept cycle.
- Backpressure: out_vld = 1 with alu_op_rdy = 0 for 3 cycles while req_vld[1] = 1 → req_rdy = 0, outputs stable; rdy rises → req 1 accepted the same cycle, new op visible the next cycle.
- Mode 1, req_vld = 4'b1111 held for 5 accepts → alu_src_id sequence 0, 1, 2, 3, 0; arb_conflict = 1 from the first cycle.
- Mode 0, req_vld = 4'b1010 → id 1 wins repeatedly, req 3 starves; arb_conflict = 1.
- Streaming: req 0 valid every cycle with alu_op_rdy = 1 → one op per cycle, no bubbles; req drops → alu_op_vld = 0 the next cycle, data held.
- Assert rst_n low mid-stream with out_vld = 1 → outputs return to 0 asynchronously; ptr = 0; arb_conflict cleared.
